// File: rtl/craft_pkg.sv
// Shared types, constants and helpers for the CRAFT tweakey stream: tweak
// permutation Q, round-constant LFSR steps and the elaboration-time RC lookup.
package craft_pkg;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam int QTab [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

  localparam logic [3:0] RcInitA = 4'h1;
  localparam logic [2:0] RcInitB = 3'h1;

  // Nibble i (0 = most significant) sits at bits [nib_lo(i) +: 4].
  function automatic int nib_lo(int i);
    return 60 - 4 * i;
  endfunction

  function automatic logic [63:0] q_perm(logic [63:0] t);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[nib_lo(i) +: 4] = t[nib_lo(QTab[i]) +: 4];
    end
    return r;
  endfunction

  function automatic logic [3:0] lfsr_a_fwd(logic [3:0] a);
    return {a[1] ^ a[0], a[3:1]};
  endfunction

  function automatic logic [2:0] lfsr_b_fwd(logic [2:0] b);
    return {b[1] ^ b[0], b[2:1]};
  endfunction

  function automatic logic [3:0] lfsr_a_inv(logic [3:0] a);
    return {a[2:0], a[3] ^ a[0]};
  endfunction

  function automatic logic [2:0] lfsr_b_inv(logic [2:0] b);
    return {b[1:0], b[2] ^ b[0]};
  endfunction

  // {a, b} after n forward steps from the initial state.
  function automatic logic [6:0] rc_after(int unsigned n);
    logic [3:0] a;
    logic [2:0] b;
    a = RcInitA;
    b = RcInitB;
    for (int unsigned i = 0; i < n; i++) begin
      a = lfsr_a_fwd(a);
      b = lfsr_b_fwd(b);
    end
    return {a, b};
  endfunction

endpackage

// File: rtl/craft_rc_lfsr.sv
// Bidirectional round-constant LFSR pair. dir=1 starts from round NR-1 and
// steps backwards; the *_next outputs feed the next round's tweakey.
module craft_rc_lfsr
  import craft_pkg::*;
#(
  parameter int unsigned NR = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  logic       dir,
  output logic [3:0] a_first,
  output logic [2:0] b_first,
  output logic [3:0] a_next,
  output logic [2:0] b_next
);

  localparam logic [6:0] RcLast = rc_after(NR - 1);

  logic [3:0] a_q;
  logic [2:0] b_q;

  assign a_first = dir ? RcLast[6:3] : RcInitA;
  assign b_first = dir ? RcLast[2:0] : RcInitB;
  assign a_next  = dir ? lfsr_a_inv(a_q) : lfsr_a_fwd(a_q);
  assign b_next  = dir ? lfsr_b_inv(b_q) : lfsr_b_fwd(b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= RcInitA;
      b_q <= RcInitB;
    end else if (load) begin
      a_q <= a_first;
      b_q <= b_first;
    end else if (step) begin
      a_q <= a_next;
      b_q <= b_next;
    end
  end

endmodule

// File: rtl/craft_tweakey_stream.sv
// Generates every CRAFT round tweakey (round constant folded in) and streams
// it DW bits per beat, MSB digit first, over a valid/ready interface.
module craft_tweakey_stream
  import craft_pkg::*;
#(
  parameter int unsigned DW = 4,
  parameter int unsigned NR = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           dec,
  input  logic [127:0]   key,
  input  logic [63:0]    tweak,
  output logic           in_ready,
  output logic [DW-1:0]  out_digit,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     out_round,
  output logic           out_last,
  output logic           busy,
  output logic           done
);

  localparam int unsigned Beats     = 64 / DW;
  localparam logic [4:0]  BeatLast  = 5'(Beats - 1);
  localparam logic [7:0]  RoundLast = 8'(NR - 1);

  state_e        state_q;
  logic [63:0]   shreg_q;
  logic [4:0]    beat_q;
  logic [7:0]    round_q;
  logic [127:0]  key_q;
  logic [63:0]   tweak_q;
  logic          dec_q;
  logic          done_q;

  logic          idle, last_beat, last_round, step;
  logic [7:0]    round_first, round_nxt;
  logic [3:0]    a_first, a_next;
  logic [2:0]    b_first, b_next;
  logic [63:0]   tk_first, tk_next;

  function automatic logic [63:0] tk_mux(logic [127:0] k, logic [63:0] t, logic [1:0] rm,
                                         logic [3:0] a, logic [2:0] b);
    logic [63:0] x;
    x = (rm[0] ? k[63:0] : k[127:64]) ^ (rm[1] ? q_perm(t) : t);
    x[47:44] = x[47:44] ^ a;
    x[43:40] = x[43:40] ^ {1'b0, b};
    return x;
  endfunction

  assign idle        = (state_q == StIdle);
  assign last_beat   = (beat_q == BeatLast);
  assign last_round  = dec_q ? (round_q == 8'd0) : (round_q == RoundLast);
  assign round_first = dec ? RoundLast : 8'd0;
  assign round_nxt   = dec_q ? round_q - 8'd1 : round_q + 8'd1;
  assign step        = !idle && out_ready && last_beat && !last_round;

  craft_rc_lfsr #(
    .NR (NR)
  ) u_rc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (idle && start),
    .step    (step),
    .dir     (idle ? dec : dec_q),
    .a_first (a_first),
    .b_first (b_first),
    .a_next  (a_next),
    .b_next  (b_next)
  );

  // First round comes straight from the ports; later rounds from latched inputs.
  assign tk_first = tk_mux(key, tweak, round_first[1:0], a_first, b_first);
  assign tk_next  = tk_mux(key_q, tweak_q, round_nxt[1:0], a_next, b_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      beat_q  <= '0;
      round_q <= '0;
      key_q   <= '0;
      tweak_q <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            key_q   <= key;
            tweak_q <= tweak;
            dec_q   <= dec;
            shreg_q <= tk_first;
            beat_q  <= '0;
            round_q <= round_first;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (out_ready) begin
            if (!last_beat) begin
              beat_q  <= beat_q + 5'd1;
              shreg_q <= shreg_q << DW;
            end else if (last_round) begin
              beat_q  <= '0;
              shreg_q <= shreg_q << DW;
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else begin
              beat_q  <= '0;
              round_q <= round_nxt;
              shreg_q <= tk_next;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = idle;
  assign out_valid = !idle;
  assign busy      = !idle;
  assign out_digit = shreg_q[63 -: DW];
  assign out_round = round_q;
  assign out_last  = !idle && last_beat;
  assign done      = done_q;

endmodule

// File: tb/tb_craft_tweakey_stream.sv
// Directed bench for craft_tweakey_stream: DW=4/NR=32, DW=16/NR=32 and DW=64/NR=1
// instances checked against hand-computed tweakeys and a forward-only model.
module tb_craft_tweakey_stream;

  logic clk, rst_n;

  logic         start4, dec4, rdy4, in_ready4, valid4, last4, busy4, done4;
  logic [127:0] key4;
  logic [63:0]  tweak4;
  logic [3:0]   digit4;
  logic [7:0]   round4;

  logic         start16, dec16, rdy16, in_ready16, valid16, last16, busy16, done16;
  logic [127:0] key16;
  logic [63:0]  tweak16;
  logic [15:0]  digit16;
  logic [7:0]   round16;

  logic         start64, dec64, rdy64, in_ready64, valid64, last64, busy64, done64;
  logic [127:0] key64;
  logic [63:0]  tweak64;
  logic [63:0]  digit64;
  logic [7:0]   round64;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] cap_tk  [32];
  logic [7:0]  cap_rnd [32];
  logic [63:0] enc2    [32];
  int          last_bad, valid_bad, done_cnt;

  craft_tweakey_stream #(.DW(4), .NR(32)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .dec(dec4), .key(key4), .tweak(tweak4),
    .in_ready(in_ready4), .out_digit(digit4), .out_valid(valid4), .out_ready(rdy4),
    .out_round(round4), .out_last(last4), .busy(busy4), .done(done4)
  );

  craft_tweakey_stream #(.DW(16), .NR(32)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .dec(dec16), .key(key16), .tweak(tweak16),
    .in_ready(in_ready16), .out_digit(digit16), .out_valid(valid16), .out_ready(rdy16),
    .out_round(round16), .out_last(last16), .busy(busy16), .done(done16)
  );

  craft_tweakey_stream #(.DW(64), .NR(1)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .dec(dec64), .key(key64), .tweak(tweak64),
    .in_ready(in_ready64), .out_digit(digit64), .out_valid(valid64), .out_ready(rdy64),
    .out_round(round64), .out_last(last64), .busy(busy64), .done(done64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Forward-only reference: LFSRs always stepped from round 0.
  function automatic logic [63:0] ref_tk(logic [127:0] k, logic [63:0] t, int r);
    int          q [16];
    logic [3:0]  a;
    logic [2:0]  b;
    logic [63:0] qt, x;
    q = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
    a = 4'h1;
    b = 3'h1;
    for (int i = 0; i < r; i++) begin
      a = {a[1] ^ a[0], a[3:1]};
      b = {b[1] ^ b[0], b[2:1]};
    end
    for (int i = 0; i < 16; i++) qt[63 - 4 * i -: 4] = t[63 - 4 * q[i] -: 4];
    x = ((r % 2) == 1 ? k[63:0] : k[127:64]) ^ ((r % 4) < 2 ? t : qt);
    x[47:44] = x[47:44] ^ a;
    x[43:40] = x[43:40] ^ {1'b0, b};
    return x;
  endfunction

  // Full 32-round job on the DW=4 instance with out_ready held high.
  task automatic job4(input logic [127:0] k, input logic [63:0] t, input logic d);
    logic [63:0] acc;
    int          nc;
    acc = '0; nc = 0; last_bad = 0; valid_bad = 0; done_cnt = 0;
    key4 = k; tweak4 = t; dec4 = d; rdy4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int n = 0; n < 32 * 16; n++) begin
      if (!valid4) valid_bad++;
      if (done4) done_cnt++;
      if (last4 !== ((n % 16) == 15)) last_bad++;
      acc = {acc[59:0], digit4};
      if ((n % 16) == 15) begin
        cap_tk[nc]  = acc;
        cap_rnd[nc] = round4;
        nc++;
      end
      @(negedge clk);
    end
    check("job_done", 64'(done4), 64'd1);
    check("job_in_ready", 64'(in_ready4), 64'd1);
    check("job_valid_off", 64'(valid4), 64'd0);
    check("job_last_flags", 64'(last_bad), 64'd0);
    check("job_valid_gaps", 64'(valid_bad), 64'd0);
    check("job_early_done", 64'(done_cnt), 64'd0);
    @(negedge clk);
    check("job_done_pulse", 64'(done4), 64'd0);
  endtask

  task automatic check_reset4(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready4), 64'd1);
    check({tag, "_valid"}, 64'(valid4), 64'd0);
    check({tag, "_digit"}, 64'(digit4), 64'd0);
    check({tag, "_round"}, 64'(round4), 64'd0);
    check({tag, "_last"}, 64'(last4), 64'd0);
    check({tag, "_busy"}, 64'(busy4), 64'd0);
    check({tag, "_done"}, 64'(done4), 64'd0);
  endtask

  initial begin
    logic [127:0] k5, k16;
    logic [63:0]  t5, t16, acc, h_dig;
    logic [7:0]   h_rnd;
    logic         h_last, hold_pend, rdy, timeout;
    int           bad5, dn5, hs, nb, rc, hold_err, rnd_err;

    rst_n = 1'b0;
    start4 = 0; dec4 = 0; rdy4 = 0; key4 = '0; tweak4 = '0;
    start16 = 0; dec16 = 0; rdy16 = 0; key16 = '0; tweak16 = '0;
    start64 = 0; dec64 = 0; rdy64 = 0; key64 = '0; tweak64 = '0;
    @(negedge clk);
    check_reset4("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: zero key/tweak, encrypt
    job4(128'h0, 64'h0, 1'b0);
    check("t1_r0", cap_tk[0], 64'h0000_1100_0000_0000);
    check("t1_r1", cap_tk[1], 64'h0000_8400_0000_0000);
    for (int r = 0; r < 32; r++) begin
      check("t1_ref", cap_tk[r], ref_tk(128'h0, 64'h0, r));
      check("t1_round_idx", 64'(cap_rnd[r]), 64'(r));
    end

    // 2: tweak 0123456789ABCDEF, encrypt
    job4(128'h0, 64'h0123_4567_89AB_CDEF, 1'b0);
    check("t2_r2", cap_tk[2], 64'hCAF5_AA92_B374_601D);
    for (int r = 0; r < 32; r++) begin
      check("t2_ref", cap_tk[r], ref_tk(128'h0, 64'h0123_4567_89AB_CDEF, r));
      enc2[r] = cap_tk[r];
    end

    // 5: start while busy, then asynchronous reset at round 10
    k5 = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    t5 = 64'h1357_9BDF_0246_8ACE;
    key4 = k5; tweak4 = t5; dec4 = 1'b0; rdy4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    acc = '0; bad5 = 0; dn5 = 0;
    for (int n = 0; n < 160; n++) begin
      if (n == 51) begin
        check("t5_in_ready_busy", 64'(in_ready4), 64'd0);
        check("t5_round_kept", 64'(round4), 64'd3);
      end
      if (done4) dn5++;
      acc = {acc[59:0], digit4};
      if ((n % 16) == 15 && acc !== ref_tk(k5, t5, n / 16)) bad5++;
      if (n == 50) begin
        start4 = 1'b1; key4 = ~k5; tweak4 = ~t5; dec4 = 1'b1;
      end else begin
        start4 = 1'b0;
      end
      @(negedge clk);
    end
    check("t5_rounds_ok", 64'(bad5), 64'd0);
    check("t5_no_done", 64'(dn5), 64'd0);
    check("t5_at_round10", 64'(round4), 64'd10);
    #2 rst_n = 1'b0;
    #1 check_reset4("t5_async");
    @(negedge clk);
    check("t5_no_done_after", 64'(done4), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3: decrypt ordering must mirror case 2
    job4(128'h0, 64'h0123_4567_89AB_CDEF, 1'b1);
    for (int i = 0; i < 32; i++) begin
      check("t3_tk", cap_tk[i], enc2[31 - i]);
      check("t3_round_idx", 64'(cap_rnd[i]), 64'(31 - i));
    end

    // 4: DW=16 with random backpressure
    k16 = {$urandom, $urandom, $urandom, $urandom};
    t16 = {$urandom, $urandom};
    key16 = k16; tweak16 = t16; dec16 = 1'b0; rdy16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    hs = 0; nb = 0; rc = 0; hold_err = 0; rnd_err = 0; hold_pend = 1'b0; timeout = 1'b1;
    acc = '0; h_dig = '0; h_rnd = '0; h_last = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done16) begin
        timeout = 1'b0;
        break;
      end
      if (hold_pend && (64'(digit16) !== h_dig || round16 !== h_rnd || last16 !== h_last ||
                        !valid16)) hold_err++;
      hold_pend = 1'b0;
      rdy = 1'($urandom_range(0, 1));
      rdy16 = rdy;
      if (valid16 && rdy) begin
        if (round16 !== 8'(rc)) rnd_err++;
        acc = {acc[47:0], digit16};
        nb++; hs++;
        if (nb == 4) begin
          check("t4_round_tk", acc, ref_tk(k16, t16, rc));
          nb = 0; rc++;
        end
      end else if (valid16) begin
        hold_pend = 1'b1; h_dig = 64'(digit16); h_rnd = round16; h_last = last16;
      end
      @(negedge clk);
    end
    rdy16 = 1'b0;
    check("t4_timeout", 64'(timeout), 64'd0);
    check("t4_handshakes", 64'(hs), 64'd128);
    check("t4_hold", 64'(hold_err), 64'd0);
    check("t4_round_idx", 64'(rnd_err), 64'd0);

    // 6: NR=1, DW=64
    key64 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    tweak64 = 64'hDEAD_BEEF_0BAD_F00D;
    rdy64 = 1'b1; start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0;
    check("t6_valid", 64'(valid64), 64'd1);
    check("t6_last", 64'(last64), 64'd1);
    check("t6_round", 64'(round64), 64'd0);
    check("t6_digit", digit64, ref_tk(key64, tweak64, 0));
    check("t6_early_done", 64'(done64), 64'd0);
    @(negedge clk);
    check("t6_done", 64'(done64), 64'd1);
    check("t6_in_ready", 64'(in_ready64), 64'd1);
    check("t6_valid_off", 64'(valid64), 64'd0);
    @(negedge clk);
    check("t6_done_pulse", 64'(done64), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
